alu_result_stage: RTL and testbench

ALU_RESULT_STAGE -- requirements
Module: alu_result_stage

---
 rtl/alu_result_stage.sv | 107 ++++++++++
 tb/tb_alu_result_stage.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_result_stage.sv
// ALU result stage: captures a 64-bit ALU result and streams it to the bus
// as one 32-bit beat, or two beats (LO then HI) for MUL/DIV.
module alu_result_stage #(
    parameter logic [4:0] MUL_OP = 5'b01110,
    parameter logic [4:0] DIV_OP = 5'b01111
) (
    input  logic        clk,
    input  logic        clear,
    input  logic [63:0] c_in,
    input  logic [4:0]  opcode,
    input  logic        zin,
    output logic        zin_ready,
    output logic [31:0] out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_hi,
    output logic        out_last,
    output logic        err_op
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SEND_LO = 2'd1,
        SEND_HI = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] z_hi_q, z_lo_q;
    logic [4:0]  op_q;
    logic [31:0] out_data_q, out_data_d;
    logic        err_q;

    logic wide_q;
    logic cap;
    logic cap_ok;
    logic cap_bad;

    function automatic logic is_supported(input logic [4:0] op);
        case (op)
            5'b00011, 5'b00100, 5'b00101, 5'b00110,
            5'b00111, 5'b01000, 5'b01001, 5'b01010,
            5'b01110, 5'b01111, 5'b10000, 5'b10001:
                is_supported = 1'b1;
            default:
                is_supported = 1'b0;
        endcase
    endfunction

    assign wide_q    = (op_q == MUL_OP) || (op_q == DIV_OP);
    assign out_valid = (state_q != IDLE);
    assign out_hi    = (state_q == SEND_HI);
    assign out_last  = (state_q == SEND_HI) ||
                       ((state_q == SEND_LO) && !wide_q);
    // A final beat leaving this cycle frees the holding registers.
    assign zin_ready = (state_q == IDLE) || (out_last && out_ready);
    assign cap       = zin && zin_ready;
    assign cap_ok    = cap && is_supported(opcode);
    assign cap_bad   = cap && !is_supported(opcode);
    assign out_data  = out_data_q;
    assign err_op    = err_q;

    always_comb begin
        state_d    = state_q;
        out_data_d = out_data_q;
        case (state_q)
            IDLE: begin
                if (cap_ok) state_d = SEND_LO;
            end
            SEND_LO: begin
                if (out_ready) begin
                    if (wide_q) begin
                        state_d    = SEND_HI;
                        out_data_d = z_hi_q;
                    end else begin
                        state_d = cap_ok ? SEND_LO : IDLE;
                    end
                end
            end
            SEND_HI: begin
                if (out_ready) state_d = cap_ok ? SEND_LO : IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (cap_ok) out_data_d = c_in[31:0];
    end

    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            state_q    <= IDLE;
            z_hi_q     <= '0;
            z_lo_q     <= '0;
            op_q       <= '0;
            out_data_q <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            out_data_q <= out_data_d;
            err_q      <= cap_bad;
            if (cap) begin
                z_hi_q <= c_in[63:32];
                z_lo_q <= c_in[31:0];
                op_q   <= opcode;
            end
        end
    end

endmodule

// File: tb/tb_alu_result_stage.sv
// Self-checking bench for alu_result_stage: scoreboard of expected beats
// plus per-scenario inline checks.
module tb_alu_result_stage;

    logic        clk = 1'b0;
    logic        clear;
    logic [63:0] c_in;
    logic [4:0]  opcode;
    logic        zin;
    logic        zin_ready;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        out_hi;
    logic        out_last;
    logic        err_op;

    typedef struct packed {
        logic [31:0] d;
        logic        hi;
        logic        last;
    } beat_t;

    beat_t sb[$];
    beat_t mon_e, mon_a;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_result_stage dut (
        .clk(clk),
        .clear(clear),
        .c_in(c_in),
        .opcode(opcode),
        .zin(zin),
        .zin_ready(zin_ready),
        .out_data(out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_hi(out_hi),
        .out_last(out_last),
        .err_op(err_op)
    );

    function automatic bit tb_supported(input logic [4:0] op);
        case (op)
            5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9,
            5'd10, 5'd14, 5'd15, 5'd16, 5'd17: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic bit tb_wide(input logic [4:0] op);
        return (op == 5'b01110) || (op == 5'b01111);
    endfunction

    // Transfers happen on the next rising edge when valid&&ready here.
    always @(negedge clk) begin
        if (clear && out_valid && out_ready) begin
            mon_a.d    = out_data;
            mon_a.hi   = out_hi;
            mon_a.last = out_last;
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL beat_unexpected: got d=%h hi=%b last=%b",
                         mon_a.d, mon_a.hi, mon_a.last);
            end else begin
                mon_e = sb.pop_front();
                if (mon_a !== mon_e) begin
                    errors++;
                    $display("FAIL beat: got d=%h hi=%b last=%b want d=%h hi=%b last=%b",
                             mon_a.d, mon_a.hi, mon_a.last,
                             mon_e.d, mon_e.hi, mon_e.last);
                end
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 after the capture edge.
    task automatic send(input logic [4:0] op, input logic [63:0] c,
                        output int waited);
        beat_t b;
        zin    = 1'b1;
        opcode = op;
        c_in   = c;
        if (tb_supported(op)) begin
            b.d = c[31:0]; b.hi = 1'b0; b.last = !tb_wide(op);
            sb.push_back(b);
            if (tb_wide(op)) begin
                b.d = c[63:32]; b.hi = 1'b1; b.last = 1'b1;
                sb.push_back(b);
            end
        end
        waited = 0;
        @(negedge clk);
        while (zin_ready !== 1'b1 && waited < 20) begin
            waited++;
            @(negedge clk);
        end
        if (zin_ready !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: zin_ready=%b want 1", zin_ready);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d beats left want 0", sb.size());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        clear = 1'b0; zin = 1'b0; opcode = '0; c_in = '0; out_ready = 1'b0;
        #12;
        checks++;
        if ({out_valid, out_hi, out_last, err_op, out_data} !== 36'h0) begin
            errors++;
            $display("FAIL reset_outputs: v=%b hi=%b last=%b err=%b d=%h want all 0",
                     out_valid, out_hi, out_last, err_op, out_data);
        end
        @(posedge clk);
        #1;
        clear = 1'b1;
        @(negedge clk);
        checks++;
        if (zin_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: zin_ready=%b v=%b want 1 0",
                     zin_ready, out_valid);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_add();
        int w;
        out_ready = 1'b1;
        send(5'b00011, 64'h0000_0000_0000_0007, w);
        zin = 1'b0;
        checks++;
        if (w != 0) begin
            errors++;
            $display("FAIL add_first_capture: waited %0d want 0", w);
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || out_data !== 32'd7 ||
            out_last !== 1'b1 || out_hi !== 1'b0) begin
            errors++;
            $display("FAIL add_latency: v=%b d=%h last=%b hi=%b want 1 7 1 0",
                     out_valid, out_data, out_last, out_hi);
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || out_data !== 32'd7 || out_last !== 1'b0) begin
            errors++;
            $display("FAIL add_idle_hold: v=%b d=%h last=%b want 0 7 0",
                     out_valid, out_data, out_last);
        end
        drain();
    endtask

    task automatic test_mul_stall();
        int w;
        out_ready = 1'b0;
        send(5'b01110, 64'h0000_0001_8000_0000, w);
        zin = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1 || out_data !== 32'h8000_0000 ||
                out_hi !== 1'b0 || out_last !== 1'b0 || zin_ready !== 1'b0) begin
                errors++;
                $display("FAIL mul_stall[%0d]: v=%b d=%h hi=%b last=%b rdy=%b want 1 80000000 0 0 0",
                         i, out_valid, out_data, out_hi, out_last, zin_ready);
            end
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (zin_ready !== 1'b0) begin
            errors++;
            $display("FAIL mul_lo_ready: zin_ready=%b want 0", zin_ready);
        end
        @(negedge clk);
        checks++;
        if (out_hi !== 1'b1 || out_data !== 32'h0000_0001 ||
            out_last !== 1'b1 || zin_ready !== 1'b1) begin
            errors++;
            $display("FAIL mul_hi: hi=%b d=%h last=%b rdy=%b want 1 00000001 1 1",
                     out_hi, out_data, out_last, zin_ready);
        end
        drain();
    endtask

    task automatic test_back_to_back();
        logic [4:0] ops [7];
        int w;
        bit prev_wide;
        ops = '{5'b00101, 5'b00110, 5'b01110, 5'b00011,
                5'b01111, 5'b10001, 5'b01010};
        out_ready = 1'b1;
        prev_wide = 1'b0;
        for (int i = 0; i < 7; i++) begin
            logic [63:0] c;
            c = (i == 6) ? 64'hFFFF_FFFF_FFFF_FFFF
                         : {$urandom(), $urandom()};
            send(ops[i], c, w);
            checks++;
            if (w != (prev_wide ? 1 : 0)) begin
                errors++;
                $display("FAIL b2b_wait[%0d]: waited %0d want %0d",
                         i, w, prev_wide ? 1 : 0);
            end
            prev_wide = tb_wide(ops[i]);
        end
        zin = 1'b0;
        drain();
    endtask

    task automatic test_unsupported();
        int w;
        out_ready = 1'b1;
        send(5'b11111, {$urandom(), $urandom()}, w);
        zin = 1'b0;
        @(negedge clk);
        checks++;
        if (err_op !== 1'b1 || out_valid !== 1'b0 || zin_ready !== 1'b1) begin
            errors++;
            $display("FAIL unsup_pulse: err=%b v=%b rdy=%b want 1 0 1",
                     err_op, out_valid, zin_ready);
        end
        @(negedge clk);
        checks++;
        if (err_op !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL unsup_after: err=%b v=%b want 0 0", err_op, out_valid);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid_div();
        int w;
        beat_t dropped;
        out_ready = 1'b1;
        send(5'b01111, 64'hDEAD_BEEF_0000_1234, w);
        zin = 1'b0;
        dropped = sb.pop_back();
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || out_hi !== 1'b1 || out_data !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL div_hi: v=%b hi=%b d=%h want 1 1 deadbeef",
                     out_valid, out_hi, out_data);
        end
        #2;
        clear = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_hi !== 1'b0 ||
            out_last !== 1'b0 || out_data !== 32'h0) begin
            errors++;
            $display("FAIL div_async_reset: v=%b hi=%b last=%b d=%h want 0 0 0 0",
                     out_valid, out_hi, out_last, out_data);
        end
        @(posedge clk);
        #1;
        clear = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b0) begin
                errors++;
                $display("FAIL div_abandon[%0d]: v=%b want 0 (hi word %h)",
                         i, out_valid, dropped.d);
            end
        end
        drain();
    endtask

    initial begin
        test_reset();
        test_add();
        test_mul_stall();
        test_back_to_back();
        test_unsupported();
        test_reset_mid_div();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
